isp_blc_ctrl: RTL and testbench



---
 rtl/isp_blc_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_isp_blc_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/isp_blc_ctrl.sv
// Frame-synchronous black-level controller: measures B/Gb/Gr/R means over an optical-black window or applies manual levels.
// Optional macro BLC_CTRL_IIR_EN: auto-mode commits are smoothed with old + ((mean - old) >>> 2).
module isp_blc_ctrl #(
  parameter int BITS     = 8,
  parameter int BAYER    = 0,
  parameter int OB_LINES = 2,
  parameter int OB_COLS  = 8
) (
  input  logic            pclk,
  input  logic            rst,
  input  logic            in_href,
  input  logic            in_vsync,
  input  logic [BITS-1:0] in_raw,
  input  logic            auto_en,
  input  logic [BITS-1:0] man_b,
  input  logic [BITS-1:0] man_gb,
  input  logic [BITS-1:0] man_gr,
  input  logic [BITS-1:0] man_r,
  input  logic            man_upd,
  output logic [BITS-1:0] black_b,
  output logic [BITS-1:0] black_gb,
  output logic [BITS-1:0] black_gr,
  output logic [BITS-1:0] black_r,
  output logic            busy,
  output logic            upd_done,
  output logic [1:0]      dbg_state
);

  localparam int SHIFT  = $clog2(OB_LINES * OB_COLS / 4);
  localparam int ACC_W  = BITS + SHIFT;
  localparam int PIX_W  = $clog2(OB_COLS + 1);
  localparam int LINE_W = $clog2(OB_LINES + 1);
  localparam logic [PIX_W-1:0]  OB_COLS_L  = PIX_W'(OB_COLS);
  localparam logic [LINE_W-1:0] OB_LINES_L = LINE_W'(OB_LINES);
  localparam logic [1:0]        BAYER_L    = 2'(BAYER);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACC    = 2'd1,
    S_HOLD   = 2'd2,
    S_COMMIT = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic               vs_q, hr_q;
  logic [PIX_W-1:0]   pix_cnt_q, pix_cnt_d;
  logic [LINE_W-1:0]  line_cnt_q, line_cnt_d;
  logic               mode_q, mode_d;
  logic               meas_ok_q, meas_ok_d;
  logic               pending_q, pending_d;
  logic               upd_done_q, upd_done_d;
  logic [ACC_W-1:0]   acc_q [4];
  logic [ACC_W-1:0]   acc_d [4];
  logic [BITS-1:0]    black_q [4];
  logic [BITS-1:0]    black_d [4];
  logic [BITS-1:0]    shadow_q [4];
  logic [BITS-1:0]    shadow_d [4];
  logic [BITS-1:0]    mean [4];
  logic               fs, fe, le, acc_hit;
  logic [1:0]         ch;

`ifdef BLC_CTRL_IIR_EN
  function automatic logic [BITS-1:0] commit_val(input logic [BITS-1:0] old_v,
                                                 input logic [BITS-1:0] mean_v);
    logic signed [BITS:0]   diff;
    logic signed [BITS:0]   step;
    logic signed [BITS+1:0] sum;
    diff = $signed({1'b0, mean_v}) - $signed({1'b0, old_v});
    step = diff >>> 2;
    sum  = $signed({2'b00, old_v}) + $signed({step[BITS], step});
    if (sum < 0)
      commit_val = '0;
    else if (sum > $signed({2'b00, {BITS{1'b1}}}))
      commit_val = '1;
    else
      commit_val = sum[BITS-1:0];
  endfunction
`else
  function automatic logic [BITS-1:0] commit_val(input logic [BITS-1:0] old_v,
                                                 input logic [BITS-1:0] mean_v);
    logic unused_old;
    unused_old = ^old_v;
    commit_val = mean_v;
  endfunction
`endif

  assign fs = ~in_vsync & vs_q;
  assign fe = in_vsync & ~vs_q;
  assign le = ~in_href & hr_q;
  assign ch = {line_cnt_q[0] ^ BAYER_L[1], pix_cnt_q[0] ^ BAYER_L[0]};
  assign acc_hit = in_href && (pix_cnt_q < OB_COLS_L) && (line_cnt_q < OB_LINES_L);

  always_comb begin
    for (int i = 0; i < 4; i++) mean[i] = acc_q[i][ACC_W-1:SHIFT];
  end

  always_comb begin
    pix_cnt_d = '0;
    if (in_href) pix_cnt_d = (pix_cnt_q == OB_COLS_L) ? pix_cnt_q : pix_cnt_q + 1'b1;
    line_cnt_d = line_cnt_q;
    if (fs) line_cnt_d = '0;
    else if (le && line_cnt_q != OB_LINES_L) line_cnt_d = line_cnt_q + 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    meas_ok_d  = meas_ok_q;
    pending_d  = pending_q;
    upd_done_d = 1'b0;
    acc_d      = acc_q;
    black_d    = black_q;
    shadow_d   = shadow_q;
    // A frame start in any state restarts the frame; an aborted frame never commits.
    if (fs) begin
      for (int i = 0; i < 4; i++) acc_d[i] = '0;
      mode_d    = auto_en;
      meas_ok_d = 1'b0;
      state_d   = auto_en ? S_ACC : S_HOLD;
    end else begin
      case (state_q)
        S_ACC: begin
          if (acc_hit) acc_d[ch] = acc_q[ch] + ACC_W'(in_raw);
          if (line_cnt_q == OB_LINES_L) begin
            meas_ok_d = 1'b1;
            state_d   = fe ? S_COMMIT : S_HOLD;
          end else if (fe) begin
            meas_ok_d = 1'b0;
            state_d   = S_COMMIT;
          end
        end
        S_HOLD: begin
          if (fe) state_d = S_COMMIT;
        end
        S_COMMIT: begin
          if (mode_q && meas_ok_q) begin
            for (int i = 0; i < 4; i++) black_d[i] = commit_val(black_q[i], mean[i]);
            upd_done_d = 1'b1;
          end else if (!mode_q && pending_q) begin
            black_d    = shadow_q;
            pending_d  = 1'b0;
            upd_done_d = 1'b1;
          end
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
    // A host update landing on the commit cycle stays pending for the next frame end.
    if (man_upd) begin
      shadow_d[0] = man_b;
      shadow_d[1] = man_gb;
      shadow_d[2] = man_gr;
      shadow_d[3] = man_r;
      pending_d   = 1'b1;
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      vs_q       <= 1'b0;
      hr_q       <= 1'b0;
      pix_cnt_q  <= '0;
      line_cnt_q <= '0;
      mode_q     <= 1'b0;
      meas_ok_q  <= 1'b0;
      pending_q  <= 1'b0;
      upd_done_q <= 1'b0;
      acc_q      <= '{default: '0};
      black_q    <= '{default: '0};
      shadow_q   <= '{default: '0};
    end else begin
      state_q    <= state_d;
      vs_q       <= in_vsync;
      hr_q       <= in_href;
      pix_cnt_q  <= pix_cnt_d;
      line_cnt_q <= line_cnt_d;
      mode_q     <= mode_d;
      meas_ok_q  <= meas_ok_d;
      pending_q  <= pending_d;
      upd_done_q <= upd_done_d;
      acc_q      <= acc_d;
      black_q    <= black_d;
      shadow_q   <= shadow_d;
    end
  end

  assign black_b   = black_q[0];
  assign black_gb  = black_q[1];
  assign black_gr  = black_q[2];
  assign black_r   = black_q[3];
  assign upd_done  = upd_done_q;
  assign busy      = (state_q == S_ACC) || (state_q == S_HOLD);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_isp_blc_ctrl.sv
// Directed bench for isp_blc_ctrl (BGGR, OB 2x8, 12-pixel lines); expected levels come from a small commit model.
module tb_isp_blc_ctrl;

  logic       pclk = 1'b0;
  logic       rst;
  logic       in_href, in_vsync;
  logic [7:0] in_raw;
  logic       auto_en;
  logic [7:0] man_b, man_gb, man_gr, man_r;
  logic       man_upd;
  logic [7:0] black_b, black_gb, black_gr, black_r;
  logic       busy, upd_done;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int upd_cnt  = 0;
  int exp_black [4];
  logic [7:0] ob [0:1][0:7];

  isp_blc_ctrl #(.BITS(8), .BAYER(0), .OB_LINES(2), .OB_COLS(8)) dut (
    .pclk(pclk), .rst(rst), .in_href(in_href), .in_vsync(in_vsync), .in_raw(in_raw),
    .auto_en(auto_en), .man_b(man_b), .man_gb(man_gb), .man_gr(man_gr), .man_r(man_r),
    .man_upd(man_upd), .black_b(black_b), .black_gb(black_gb), .black_gr(black_gr),
    .black_r(black_r), .busy(busy), .upd_done(upd_done), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 pclk = ~pclk;

  always @(negedge pclk) if (upd_done === 1'b1) upd_cnt++;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_black(input string tag);
    check({tag, "_b"},  32'(black_b),  32'(exp_black[0]));
    check({tag, "_gb"}, 32'(black_gb), 32'(exp_black[1]));
    check({tag, "_gr"}, 32'(black_gr), 32'(exp_black[2]));
    check({tag, "_r"},  32'(black_r),  32'(exp_black[3]));
  endtask

  function automatic int model_commit(input int old_v, input int mean_v);
`ifdef BLC_CTRL_IIR_EN
    int d;
    int r;
    d = mean_v - old_v;
    r = old_v + (d >>> 2);
    if (r < 0) r = 0;
    if (r > 255) r = 255;
    return r;
`else
    return mean_v + 0 * old_v;
`endif
  endfunction

  task automatic model_auto(input int m0, input int m1, input int m2, input int m3);
    exp_black[0] = model_commit(exp_black[0], m0);
    exp_black[1] = model_commit(exp_black[1], m1);
    exp_black[2] = model_commit(exp_black[2], m2);
    exp_black[3] = model_commit(exp_black[3], m3);
  endtask

  task automatic set_const(input logic [7:0] b, input logic [7:0] gb,
                           input logic [7:0] gr, input logic [7:0] r);
    for (int c = 0; c < 8; c++) begin
      ob[0][c] = (c % 2 == 0) ? b  : gb;
      ob[1][c] = (c % 2 == 0) ? gr : r;
    end
  endtask

  // driver tasks
  task automatic send_line(input int l);
    for (int c = 0; c < 12; c++) begin
      in_href = 1'b1;
      in_raw  = (l < 2 && c < 8) ? ob[l][c] : 8'hFF;
      tick();
    end
    in_href = 1'b0;
    in_raw  = 8'h00;
    repeat (4) tick();
  endtask

  task automatic start_frame();
    in_vsync = 1'b1;
    repeat (3) tick();
    in_vsync = 1'b0;
    repeat (3) tick();
  endtask

  task automatic end_frame();
    in_vsync = 1'b1;
    repeat (6) tick();
  endtask

  task automatic run_frame(input int nlines, input string tag, input int exp_upd);
    int u0;
    u0 = upd_cnt;
    start_frame();
    for (int l = 0; l < nlines; l++) send_line(l);
    end_frame();
    check({tag, "_upd_cnt"}, 32'(upd_cnt - u0), 32'(exp_upd));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) exp_black[i] = 0;
  endtask

  initial begin
    int u0;
    rst = 1'b1; in_href = 1'b0; in_vsync = 1'b1; in_raw = '0; auto_en = 1'b0;
    man_b = '0; man_gb = '0; man_gr = '0; man_r = '0; man_upd = 1'b0;
    for (int i = 0; i < 4; i++) exp_black[i] = 0;
    repeat (3) tick();
    chk_black("reset");
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_upd", 32'(upd_done), 32'd0);
    rst = 1'b0;
    tick();

    // 1: constant OB levels, exact commit timing
    auto_en = 1'b1;
    set_const(8'd16, 8'd18, 8'd20, 8'd24);
    u0 = upd_cnt;
    start_frame();
    check("t1_busy_mid", 32'(busy), 32'd1);
    for (int l = 0; l < 3; l++) send_line(l);
    chk_black("t1_before_fe");
    in_vsync = 1'b1;
    tick();
    check("t1_upd_edge1", 32'(upd_done), 32'd0);
    tick();
    model_auto(16, 18, 20, 24);
    check("t1_upd_edge2", 32'(upd_done), 32'd1);
    chk_black("t1");
    tick();
    check("t1_upd_edge3", 32'(upd_done), 32'd0);
    check("t1_busy_after", 32'(busy), 32'd0);
    repeat (3) tick();
    check("t1_upd_cnt", 32'(upd_cnt - u0), 32'd1);

    // 2: floor of B mean (42/4), others zero
    set_const(8'd0, 8'd0, 8'd0, 8'd0);
    ob[0][0] = 8'd10; ob[0][2] = 8'd11; ob[0][4] = 8'd10; ob[0][6] = 8'd11;
    run_frame(3, "t2", 1);
    model_auto(10, 0, 0, 0);
    chk_black("t2");

    // 3: manual update applied only at frame end, then held
    do_reset();
    auto_en = 1'b0;
    man_b = 8'd5; man_gb = 8'd6; man_gr = 8'd7; man_r = 8'd8;
    u0 = upd_cnt;
    start_frame();
    send_line(0);
    man_upd = 1'b1;
    tick();
    man_upd = 1'b0;
    send_line(1);
    send_line(2);
    chk_black("t3_mid");
    check("t3_busy_hold", 32'(busy), 32'd1);
    end_frame();
    check("t3_upd_cnt", 32'(upd_cnt - u0), 32'd1);
    exp_black[0] = 5; exp_black[1] = 6; exp_black[2] = 7; exp_black[3] = 8;
    chk_black("t3");
    run_frame(3, "t3_nopend", 0);
    chk_black("t3_held");

    // 4: short frame in auto mode leaves levels alone
    auto_en = 1'b1;
    run_frame(1, "t4", 0);
    chk_black("t4");

    // 5: man_upd in the commit cycle waits one frame; auto_en flip mid-frame ignored
    auto_en = 1'b0;
    man_b = 8'd1; man_gb = 8'd2; man_gr = 8'd3; man_r = 8'd4;
    start_frame();
    send_line(0);
    man_upd = 1'b1;
    tick();
    man_upd = 1'b0;
    auto_en = 1'b1;
    send_line(1);
    send_line(2);
    in_vsync = 1'b1;
    tick();
    man_b = 8'd9; man_gb = 8'd9; man_gr = 8'd9; man_r = 8'd9;
    man_upd = 1'b1;
    tick();
    man_upd = 1'b0;
    check("t5_upd", 32'(upd_done), 32'd1);
    exp_black[0] = 1; exp_black[1] = 2; exp_black[2] = 3; exp_black[3] = 4;
    chk_black("t5_first");
    repeat (4) tick();
    auto_en = 1'b0;
    run_frame(3, "t5_next", 1);
    for (int i = 0; i < 4; i++) exp_black[i] = 9;
    chk_black("t5_next");

    // 6: three auto frames at mean 40 from zero (smoothed when the IIR is built in)
    do_reset();
    auto_en = 1'b1;
    set_const(8'd40, 8'd40, 8'd40, 8'd40);
    for (int f = 0; f < 3; f++) begin
      run_frame(3, $sformatf("t6_f%0d", f), 1);
      model_auto(40, 40, 40, 40);
      chk_black($sformatf("t6_f%0d", f));
    end

    // 7: reset released mid-frame measures nothing for that frame
    in_vsync = 1'b0;
    tick();
    do_reset();
    u0 = upd_cnt;
    for (int l = 0; l < 3; l++) send_line(l);
    check("t7_busy", 32'(busy), 32'd0);
    end_frame();
    check("t7_upd_cnt", 32'(upd_cnt - u0), 32'd0);
    chk_black("t7");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
